// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter for CP0: synchronises irq lines, prioritises traps over
// interrupts, and emits a one-cycle take event, then blocks further takes until eret.
module exc_ctrl #(
  parameter int NIRQ        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     status,
  input  logic            instr_valid,
  input  logic [31:0]     instr_pc,
  input  logic            stall,
  input  logic            syscall,
  input  logic            brk,
  input  logic            teq_trap,
  input  logic            eret,
  input  logic            irq_ack,
  input  logic [2:0]      irq_ack_id,
  output logic            exception,
  output logic            intr,
  output logic [4:0]      cause,
  output logic [31:0]     epc,
  output logic [2:0]      irq_id,
  output logic            in_handler,
  output logic            double_fault
);

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_e;

  localparam logic [4:0] CAUSE_SYS = 5'b01000;
  localparam logic [4:0] CAUSE_BRK = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ = 5'b01101;
  localparam logic [4:0] CAUSE_INT = 5'b00000;

  state_e          state_q, state_d;
  logic [NIRQ-1:0] sync_q [SYNC_STAGES];
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [2:0]      irq_id_q, irq_id_d;
  logic            dfault_q, dfault_d;

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] pend_en;
  logic [2:0]      lowest_id;
  logic            sys_en, brk_en, teq_en;
  logic            sync_req, int_req;

  // Synchroniser chain and edge detector; irq_prev_q holds the previous synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      irq_prev_q <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      irq_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_edge = sync_q[SYNC_STAGES-1] & ~irq_prev_q;

  // Ack clears first, so a fresh edge on the same line in the same cycle wins.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_ack && (irq_ack_id == 3'(i))) pend_d[i] = 1'b0;
    end
    pend_d = pend_d | irq_edge;
  end

  assign pend_en = pend_q & status[8 +: NIRQ];

  always_comb begin
    lowest_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend_en[i]) lowest_id = 3'(i);
    end
  end

  assign sys_en   = syscall  & status[1];
  assign brk_en   = brk      & status[2];
  assign teq_en   = teq_trap & status[3];
  assign sync_req = sys_en | brk_en | teq_en;
  assign int_req  = status[4] & (|pend_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      irq_id_q <= '0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      irq_id_q <= irq_id_d;
      dfault_q <= dfault_d;
    end
  end

  // Take outputs are gated by rst_n so they read 0 throughout reset.
  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    dfault_d  = dfault_q;
    exception = 1'b0;
    intr      = 1'b0;
    cause     = '0;
    epc       = '0;
    unique case (state_q)
      IDLE: begin
        if (rst_n && instr_valid && !stall && status[0] && (sync_req || int_req)) begin
          state_d = HANDLER;
          epc     = instr_pc;
          if (sys_en) begin
            exception = 1'b1;
            cause     = CAUSE_SYS;
          end else if (brk_en) begin
            exception = 1'b1;
            cause     = CAUSE_BRK;
          end else if (teq_en) begin
            exception = 1'b1;
            cause     = CAUSE_TEQ;
          end else begin
            intr     = 1'b1;
            cause    = CAUSE_INT;
            irq_id_d = lowest_id;
          end
        end
      end
      HANDLER: begin
        if (instr_valid && (syscall || brk || teq_trap)) dfault_d = 1'b1;
        if (eret && instr_valid && !stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_id       = irq_id_q;
  assign in_handler   = (state_q == HANDLER);
  assign double_fault = dfault_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: inputs change 1ns after the rising edge, outputs are
// checked 1ns after that, well clear of the next edge.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic [31:0] status;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        stall, syscall, brk, teq_trap, eret, irq_ack;
  logic [2:0]  irq_ack_id;
  logic        exception, intr, in_handler, double_fault;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [2:0]  irq_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.NIRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .status(status),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .stall(stall),
    .syscall(syscall), .brk(brk), .teq_trap(teq_trap), .eret(eret),
    .irq_ack(irq_ack), .irq_ack_id(irq_ack_id),
    .exception(exception), .intr(intr), .cause(cause), .epc(epc),
    .irq_id(irq_id), .in_handler(in_handler), .double_fault(double_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; status = 32'h0000_001F; instr_valid = 1'b0;
    instr_pc = '0; stall = 1'b0; syscall = 1'b0; brk = 1'b0; teq_trap = 1'b0;
    eret = 1'b0; irq_ack = 1'b0; irq_ack_id = '0;

    // Requests during reset must not produce a take
    tick();
    instr_valid = 1'b1; syscall = 1'b1; instr_pc = 32'h0000_1234; #1;
    chk("rst_exception", {31'b0, exception}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    instr_valid = 1'b0; syscall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); #1;

    // 1: idle after reset
    chk("t1_exception", {31'b0, exception}, 32'd0);
    chk("t1_intr", {31'b0, intr}, 32'd0);
    chk("t1_cause", {27'b0, cause}, 32'd0);
    chk("t1_epc", epc, 32'd0);
    chk("t1_in_handler", {31'b0, in_handler}, 32'd0);
    chk("t1_irq_id", {29'b0, irq_id}, 32'd0);

    // 2: syscall take, then eret
    instr_valid = 1'b1; syscall = 1'b1; instr_pc = 32'h0040_0020; #1;
    chk("t2_exception", {31'b0, exception}, 32'd1);
    chk("t2_intr", {31'b0, intr}, 32'd0);
    chk("t2_cause", {27'b0, cause}, 32'h08);
    chk("t2_epc", epc, 32'h0040_0020);
    tick();
    instr_valid = 1'b0; syscall = 1'b0; #1;
    chk("t2_in_handler", {31'b0, in_handler}, 32'd1);
    chk("t2_pulse_end", {31'b0, exception}, 32'd0);
    chk("t2_epc_zero", epc, 32'd0);
    instr_valid = 1'b1; eret = 1'b1;
    tick();
    instr_valid = 1'b0; eret = 1'b0; #1;
    chk("t2_eret", {31'b0, in_handler}, 32'd0);

    // 3: irq[2] rise takes 3 clocks to reach pend
    status = 32'h0000_041F; irq[2] = 1'b1;
    instr_valid = 1'b1; instr_pc = 32'h0040_0100; #1;
    chk("t3_lat0", {31'b0, intr}, 32'd0);
    tick(); #1;
    chk("t3_lat1", {31'b0, intr}, 32'd0);
    tick(); #1;
    chk("t3_lat2", {31'b0, intr}, 32'd0);
    tick(); #1;
    chk("t3_intr", {31'b0, intr}, 32'd1);
    chk("t3_exception", {31'b0, exception}, 32'd0);
    chk("t3_cause", {27'b0, cause}, 32'd0);
    chk("t3_epc", epc, 32'h0040_0100);
    tick();
    instr_valid = 1'b0; #1;
    chk("t3_irq_id", {29'b0, irq_id}, 32'd2);
    chk("t3_in_handler", {31'b0, in_handler}, 32'd1);
    irq_ack = 1'b1; irq_ack_id = 3'd2;
    tick();
    irq_ack = 1'b0; instr_valid = 1'b1; eret = 1'b1;
    tick();
    eret = 1'b0; #1;
    chk("t3_back_idle", {31'b0, in_handler}, 32'd0);
    chk("t3_ack_cleared", {31'b0, intr}, 32'd0);

    // 4: brk+teq with an enabled pending irq[0]; brk wins, interrupt follows eret
    status = 32'h0000_011F; irq[0] = 1'b1; instr_valid = 1'b0;
    tick(); tick(); tick();
    instr_valid = 1'b1; brk = 1'b1; teq_trap = 1'b1; instr_pc = 32'h0040_0200; #1;
    chk("t4_exception", {31'b0, exception}, 32'd1);
    chk("t4_cause", {27'b0, cause}, 32'h09);
    chk("t4_intr", {31'b0, intr}, 32'd0);
    tick();
    brk = 1'b0; teq_trap = 1'b0; instr_valid = 1'b0; #1;
    chk("t4_in_handler", {31'b0, in_handler}, 32'd1);
    chk("t4_no_dfault", {31'b0, double_fault}, 32'd0);
    instr_valid = 1'b1; eret = 1'b1;
    tick();
    eret = 1'b0; instr_pc = 32'h0040_0204; #1;
    chk("t4_intr_after", {31'b0, intr}, 32'd1);
    chk("t4_exc_after", {31'b0, exception}, 32'd0);
    chk("t4_cause_after", {27'b0, cause}, 32'd0);
    chk("t4_epc_after", epc, 32'h0040_0204);
    tick();
    instr_valid = 1'b0; #1;
    chk("t4_irq_id", {29'b0, irq_id}, 32'd0);
    irq_ack = 1'b1; irq_ack_id = 3'd0; instr_valid = 1'b1; eret = 1'b1;
    tick();
    irq_ack = 1'b0; eret = 1'b0; #1;
    chk("t4_back_idle", {31'b0, in_handler}, 32'd0);
    chk("t4_ack_cleared", {31'b0, intr}, 32'd0);

    // 5: stall holds off a syscall without losing it
    syscall = 1'b1; stall = 1'b1; instr_pc = 32'h0040_0300;
    repeat (4) begin
      #1;
      chk("t5_stalled", {31'b0, exception}, 32'd0);
      tick();
    end
    chk("t5_stall_idle", {31'b0, in_handler}, 32'd0);
    stall = 1'b0; #1;
    chk("t5_exception", {31'b0, exception}, 32'd1);
    chk("t5_cause", {27'b0, cause}, 32'h08);
    chk("t5_epc", epc, 32'h0040_0300);
    tick();
    syscall = 1'b0; instr_valid = 1'b0; #1;
    chk("t5_in_handler", {31'b0, in_handler}, 32'd1);

    // 6a: trap while in handler sets sticky double_fault, no pulse
    instr_valid = 1'b1; teq_trap = 1'b1; #1;
    chk("t6_no_pulse", {31'b0, exception}, 32'd0);
    chk("t6_dfault_pre", {31'b0, double_fault}, 32'd0);
    tick();
    teq_trap = 1'b0; instr_valid = 1'b0; #1;
    chk("t6_dfault_set", {31'b0, double_fault}, 32'd1);
    instr_valid = 1'b1; eret = 1'b1;
    tick();
    eret = 1'b0; instr_valid = 1'b0; #1;
    chk("t6_idle", {31'b0, in_handler}, 32'd0);
    chk("t6_dfault_sticky", {31'b0, double_fault}, 32'd1);

    // 6b: global enable off keeps pending irq[3] from being taken
    status = 32'h0000_081E;
    irq[3] = 1'b1; instr_valid = 1'b1; instr_pc = 32'h0040_0400;
    repeat (5) begin
      tick(); #1;
      chk("t6_gdis", {31'b0, intr}, 32'd0);
    end
    status = 32'h0000_081F; #1;
    chk("t6_genable_intr", {31'b0, intr}, 32'd1);
    tick(); #1;
    chk("t6_irq_id", {29'b0, irq_id}, 32'd3);
    chk("t6_in_handler", {31'b0, in_handler}, 32'd1);

    // 6c: reset mid-handler
    irq = '0; syscall = 1'b1; rst_n = 1'b0; #1;
    chk("t6_rst_handler", {31'b0, in_handler}, 32'd0);
    chk("t6_rst_dfault", {31'b0, double_fault}, 32'd0);
    chk("t6_rst_irq_id", {29'b0, irq_id}, 32'd0);
    chk("t6_rst_exception", {31'b0, exception}, 32'd0);
    chk("t6_rst_intr", {31'b0, intr}, 32'd0);
    chk("t6_rst_cause", {27'b0, cause}, 32'd0);
    chk("t6_rst_epc", epc, 32'd0);
    tick(); tick();
    syscall = 1'b0; rst_n = 1'b1; #1;
    chk("t6_post_rst_intr", {31'b0, intr}, 32'd0);
    tick(); #1;
    chk("t6_post_rst_intr2", {31'b0, intr}, 32'd0);
    chk("t6_post_rst_handler", {31'b0, in_handler}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
